// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned       DEF_PC_STEP  = 4;

  // RST: one settling cycle after reset; REQ: request offered to memory;
  // WAIT: one request outstanding; HOLD: instruction presented to decode.
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Instruction fetches are always word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_plus4.sv
// Combinational sequential-PC adder; wraps modulo 2^ADDR_W.
module pc_plus4
  import fetch_pkg::*;
#(
  parameter int unsigned STEP = DEF_PC_STEP
) (
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] sum_o
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  assign sum_o = pc_i + STEP_W;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one fetch at a time,
// presents returned words to decode and handles redirects from execute.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4,
  input  logic              inst_ready
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = word_align(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
  logic              req_valid_q;
  logic              inst_valid_q;

  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] req_pc4_s;
  logic [ADDR_W-1:0] redir_pc_s;

  assign redir_pc_s = word_align(redirect_pc);

  pc_plus4 #(.STEP(PC_STEP)) u_pc_next (
    .pc_i  (pc_q),
    .sum_o (pc_next_s)
  );

  pc_plus4 #(.STEP(PC_STEP)) u_req_pc4 (
    .pc_i  (req_pc_q),
    .sum_o (req_pc4_s)
  );

  // Next-state and datapath selection; a redirect outranks every other event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    out_data_d = out_data_q;
    out_pc_d   = out_pc_q;
    out_pc4_d  = out_pc4_q;

    case (state_q)
      ST_RST: begin
        // Redirects are ignored while settling out of reset.
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (imem_req_ready) begin
          // The old-path request completes anyway; mark its response for discard.
          req_pc_d = pc_q;
          drop_d   = redirect_valid;
          state_d  = ST_WAIT;
        end else begin
          state_d  = ST_REQ;
        end

        if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else if (imem_req_ready) begin
          pc_d = pc_next_s;
        end else begin
          pc_d = pc_q;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else begin
          pc_d = pc_q;
        end

        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = ST_REQ;
          end else begin
            out_data_d = imem_rsp_data;
            out_pc_d   = req_pc_q;
            out_pc4_d  = req_pc4_s;
            state_d    = ST_HOLD;
          end
        end else begin
          drop_d  = drop_q | redirect_valid;
          state_d = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          // The held instruction is flushed whether or not decode took it.
          pc_d    = redir_pc_s;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State, PC, drop flag and output register, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC_W;
      req_pc_q     <= 32'h0000_0000;
      drop_q       <= 1'b0;
      out_data_q   <= 32'h0000_0000;
      out_pc_q     <= 32'h0000_0000;
      out_pc4_q    <= 32'h0000_0000;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      req_valid_q  <= (state_d == ST_REQ);
      inst_valid_q <= (state_d == ST_HOLD);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = out_data_q;
  assign inst_pc        = out_pc_q;
  assign inst_pc4       = out_pc4_q;

endmodule
